// File: rtl/mem_arbiter.sv
// Memory bus arbiter: instruction fetch and load/store share one bus with a single outstanding
// transaction; load/store has priority, bounded by a starvation counter that forces IF through.
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               owner_d, owner_d_nxt;
  logic [CNT_W-1:0]   starve_cnt, starve_nxt;
  logic               if_win, d_win;

  logic               if_gnt_nxt, d_gnt_nxt, if_rvalid_nxt, d_rvalid_nxt;
  logic [DATA_W-1:0]  if_rdata_nxt, d_rdata_nxt;
  logic               bus_req_nxt, bus_we_nxt, busy_nxt;
  logic [ADDR_W-1:0]  bus_addr_nxt;
  logic [DATA_W-1:0]  bus_wdata_nxt;
  logic [MASK_W-1:0]  bus_wmask_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == STARVE_LIM) return cnt;
    return cnt + CNT_W'(1);
  endfunction

  assign if_win = if_req && (!d_req || (starve_cnt == STARVE_LIM));
  assign d_win  = !if_win && d_req;

  always_comb begin
    state_nxt     = state;
    owner_d_nxt   = owner_d;
    starve_nxt    = starve_cnt;
    if_gnt_nxt    = 1'b0;
    d_gnt_nxt     = 1'b0;
    if_rvalid_nxt = 1'b0;
    d_rvalid_nxt  = 1'b0;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    bus_req_nxt   = bus_req;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    bus_wmask_nxt = bus_wmask;

    case (state)
      ST_IDLE: begin
        if (if_win) begin
          state_nxt     = ST_REQ;
          owner_d_nxt   = 1'b0;
          starve_nxt    = '0;
          if_gnt_nxt    = 1'b1;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = 1'b0;
          bus_addr_nxt  = if_addr;
          bus_wdata_nxt = '0;
          bus_wmask_nxt = '1;
        end else if (d_win) begin
          state_nxt     = ST_REQ;
          owner_d_nxt   = 1'b1;
          d_gnt_nxt     = 1'b1;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = d_we;
          bus_addr_nxt  = d_addr;
          bus_wdata_nxt = d_wdata;
          bus_wmask_nxt = d_we ? d_wmask : '1;
          if (if_req) starve_nxt = sat_inc(starve_cnt);
        end
      end
      // Bus fields stay latched until the bus accepts; stray responses here are dropped.
      ST_REQ: begin
        if (bus_gnt) begin
          state_nxt   = ST_WAIT;
          bus_req_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid) begin
          state_nxt = ST_IDLE;
          if (owner_d) begin
            d_rvalid_nxt = 1'b1;
            d_rdata_nxt  = bus_we ? '0 : bus_rdata;
          end else begin
            if_rvalid_nxt = 1'b1;
            if_rdata_nxt  = bus_rdata;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wmask  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner_d    <= owner_d_nxt;
      starve_cnt <= starve_nxt;
      if_gnt     <= if_gnt_nxt;
      d_gnt      <= d_gnt_nxt;
      if_rvalid  <= if_rvalid_nxt;
      d_rvalid   <= d_rvalid_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      bus_req    <= bus_req_nxt;
      bus_we     <= bus_we_nxt;
      bus_addr   <= bus_addr_nxt;
      bus_wdata  <= bus_wdata_nxt;
      bus_wmask  <= bus_wmask_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural bus slave with programmable grant/response
// delays, requester tasks that push expected results, and a monitor that pops and compares them.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [63:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_wmask;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, busy;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wmask;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .busy(busy)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
  } txn_t;

  txn_t if_q[$];
  txn_t d_q[$];
  txn_t cur;
  int   gnt_log[$];
  int   d_gnt_log[$];
  int   d_rv_log[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   if_gnt_cyc, if_rv_cyc, d_gnt_cyc;
  int   d_rv_count = 0;
  int   bus_req_cnt = 0;
  bit   outstanding = 0;
  int   gnt_dly = 0;
  int   rv_dly = 1;
  bit   spur = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h1122_3344_5566_7788;
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus slave: grants gnt_dly cycles after seeing bus_req, responds rv_dly cycles after the grant.
  initial begin
    int st, cnt, rcnt;
    st = 0; cnt = 0; rcnt = 0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      case (st)
        0: if (bus_req) begin
          if (gnt_dly == 0) begin bus_gnt = 1'b1; rcnt = rv_dly; st = 2; end
          else begin cnt = gnt_dly; st = 1; end
        end
        1: begin
          cnt--;
          if (spur && cnt == 3) begin bus_rvalid = 1'b1; bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF; end
          if (cnt == 0) begin bus_gnt = 1'b1; rcnt = rv_dly; st = 2; end
        end
        default: begin
          rcnt--;
          if (rcnt == 0) begin bus_rvalid = 1'b1; bus_rdata = mem_data(bus_addr); st = 0; end
        end
      endcase
    end
  end

  // Monitor: tracks the owner of each grant, checks latched bus fields and pops results.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      outstanding = 0;
    end else begin
      if (if_gnt || d_gnt) begin
        check("gnt_exclusive", {63'd0, if_gnt & d_gnt}, 64'd0);
        check("gnt_while_busy", {63'd0, outstanding}, 64'd0);
        outstanding = 1;
      end
      if (if_gnt) begin
        gnt_log.push_back(0);
        if_gnt_cyc = cyc;
        if (if_q.size() == 0) check("if_gnt_unexpected", 64'd1, 64'd0);
        else cur = if_q[0];
      end
      if (d_gnt) begin
        gnt_log.push_back(1);
        d_gnt_log.push_back(cyc);
        d_gnt_cyc = cyc;
        if (d_q.size() == 0) check("d_gnt_unexpected", 64'd1, 64'd0);
        else cur = d_q[0];
      end
      if (bus_req) begin
        bus_req_cnt++;
        check("bus_addr", bus_addr, cur.addr);
        check("bus_we", {63'd0, bus_we}, {63'd0, cur.we});
        check("bus_wmask", {56'd0, bus_wmask}, {56'd0, cur.wmask});
        check("bus_wdata", bus_wdata, cur.wdata);
      end
      if (if_rvalid) begin
        check("if_rvalid_owner", {63'd0, d_rvalid}, 64'd0);
        if_rv_cyc = cyc;
        outstanding = 0;
        if (if_q.size() == 0) check("if_rvalid_unexpected", 64'd1, 64'd0);
        else begin txn_t t; t = if_q.pop_front(); check("if_rdata", if_rdata, t.rdata); end
      end
      if (d_rvalid) begin
        d_rv_log.push_back(cyc);
        d_rv_count++;
        outstanding = 0;
        if (d_q.size() == 0) check("d_rvalid_unexpected", 64'd1, 64'd0);
        else begin txn_t t; t = d_q.pop_front(); check("d_rdata", d_rdata, t.rdata); end
      end
    end
  end

  task automatic if_read(input logic [63:0] a);
    txn_t t;
    bit   got;
    t.addr = a; t.we = 1'b0; t.wdata = '0; t.wmask = 8'hFF; t.rdata = mem_data(a);
    if_q.push_back(t);
    if_req = 1'b1; if_addr = a;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_gnt) begin got = 1; break; end
    end
    if (!got) check("if_gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [63:0] a, input logic [63:0] wd,
                          input logic [7:0] m);
    txn_t t;
    bit   got;
    t.addr = a; t.we = we; t.wdata = wd; t.wmask = we ? m : 8'hFF; t.rdata = we ? '0 : mem_data(a);
    d_q.push_back(t);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wmask = m;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d_gnt) begin got = 1; break; end
    end
    if (!got) check("d_gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (if_q.size() == 0 && d_q.size() == 0 && !outstanding && !busy) begin done = 1; break; end
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, rv_before;
    bit got;
    logic [63:0] last_d, last_if;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ctrl", {58'd0, bus_req, if_gnt, d_gnt, if_rvalid, d_rvalid, bus_we}, 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    check("rst_bus_wmask", {56'd0, bus_wmask}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // IF read at minimum latency
    c0 = cyc;
    if_read(64'h8000_0000);
    drain();
    check("if_gnt_latency", 64'(if_gnt_cyc - c0), 64'd1);
    check("if_rvalid_latency", 64'(if_rv_cyc - c0), 64'd3);
    check("if_rdata_value", if_rdata, 64'h1122_3344_5566_7788);

    // D byte write
    rv_before = d_rv_count;
    d_access(1'b1, 64'h100, 64'hAB, 8'h01);
    drain();
    check("d_write_ack_count", 64'(d_rv_count - rv_before), 64'd1);
    check("d_write_rdata", d_rdata, 64'd0);

    // Back-to-back D reads
    d_gnt_log.delete(); d_rv_log.delete();
    d_access(1'b0, 64'h200, 64'h0, 8'h00);
    d_access(1'b0, 64'h208, 64'h0, 8'h00);
    drain();
    if (d_gnt_log.size() == 2 && d_rv_log.size() == 2)
      check("b2b_gnt_after_rvalid", 64'(d_gnt_log[1] - d_rv_log[0]), 64'd1);
    else check("b2b_counts", 64'(d_gnt_log.size()), 64'd2);

    // Delayed bus grant with a stray response in REQ
    gnt_dly = 5; spur = 1; bus_req_cnt = 0;
    d_access(1'b0, 64'h300, 64'h0, 8'h00);
    drain();
    check("delay_bus_req_cycles", 64'(bus_req_cnt), 64'd6);
    gnt_dly = 0; spur = 0;

    // Both requesters held: starvation counter forces IF every fifth grant
    gnt_log.delete();
    fork
      begin for (int i = 0; i < 8; i++) d_access(1'b0, 64'h400 + 64'(8 * i), 64'h0, 8'h00); end
      begin for (int j = 0; j < 2; j++) if_read(64'h1000 + 64'(8 * j)); end
    join
    drain();
    check("starve_grant_count", 64'(gnt_log.size()), 64'd10);
    if (gnt_log.size() == 10) begin
      for (int k = 0; k < 10; k++)
        check($sformatf("starve_order_%0d", k), 64'(gnt_log[k]), (k == 4 || k == 9) ? 64'd0 : 64'd1);
    end

    // rdata hold while rvalid is low
    last_d = mem_data(64'h400 + 64'd56);
    last_if = mem_data(64'h1008);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("d_rdata_hold", d_rdata, last_d);
    check("if_rdata_hold", if_rdata, last_if);
    @(posedge clk); #1;

    // Reset while waiting for the response
    rv_dly = 4;
    begin
      txn_t t;
      t.addr = 64'h500; t.we = 1'b0; t.wdata = '0; t.wmask = 8'hFF; t.rdata = mem_data(64'h500);
      d_q.push_back(t);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500; d_wdata = '0; d_wmask = '0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_req && bus_gnt) begin got = 1; break; end
    end
    if (!got) check("rst_test_bus_gnt_timeout", 64'd0, 64'd1);
    d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    d_q.delete();
    rv_before = d_rv_count;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_bus_req", {63'd0, bus_req}, 64'd0);
    check("midrst_bus_addr", bus_addr, 64'd0);
    check("midrst_d_rdata", d_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_rvalid", 64'(d_rv_count - rv_before), 64'd0);
    rv_dly = 1;

    // Simultaneous requests after reset: D first, then IF
    gnt_log.delete();
    fork
      d_access(1'b1, 64'h600, 64'h0000_00CD_EF00_0000, 8'hF0);
      if_read(64'h2000);
    join
    drain();
    check("simul_count", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() == 2) begin
      check("simul_first_d", 64'(gnt_log[0]), 64'd1);
      check("simul_second_if", 64'(gnt_log[1]), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
